// File: rtl/noc_local_injector_pkg.sv
// Shared NoC definitions for the local injector: node id widths, flit type
// encoding and the HEAD flit payload layout.
package noc_local_injector_pkg;

  localparam int Noc_ID_X_Width = 4;
  localparam int Noc_ID_Y_Width = 4;
  localparam int NOC_LEN_W      = 4;
  localparam int FLIT_TYPE_W    = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  // HEAD payload, zero-extended on the MSB side up to the flit data width.
  typedef struct packed {
    logic [Noc_ID_X_Width-1:0] dst_x;
    logic [Noc_ID_Y_Width-1:0] dst_y;
    logic [Noc_ID_X_Width-1:0] src_x;
    logic [Noc_ID_Y_Width-1:0] src_y;
    logic [NOC_LEN_W-1:0]      len;
  } head_payload_t;

  localparam int HEAD_PAYLOAD_W = $bits(head_payload_t);

  // TAIL and HEADTAIL both close a packet; they share the type MSB.
  function automatic logic is_last(input flit_type_e t);
    return t[FLIT_TYPE_W-1];
  endfunction

endpackage

// File: rtl/noc_flit_interface.sv
// Flit link between a sender and a router input port. flit is a one-entry
// packed array so the link can later be widened to several flits per cycle.
interface Noc_flit_interface #(
  parameter int VC_NUM = 2,
  parameter int FLIT_W = 35
);
  logic                         valid;
  logic                         ready;
  logic [0:0][FLIT_W-1:0]       flit;
  logic [VC_NUM-1:0]            vc_ready;

  modport sender  (output valid, output flit, input  ready, input  vc_ready);
  modport receiver(input  valid, input  flit, output ready, output vc_ready);
endinterface

// File: rtl/noc_flit_out_reg.sv
// One-entry valid/ready output register. A held flit stays stable until the
// receiver takes it; a new flit may be loaded when empty or draining.
module noc_flit_out_reg #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         can_load
);

  assign can_load = !valid || ready;

  // Load wins over drain so back-to-back flits leave without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_local_injector.sv
// Tile-side packetizer: turns a descriptor plus payload words into
// HEAD/BODY/TAIL flits on one VC held for the whole packet.
// Optional statistics counters: define NOC_INJ_STATS_EN.
module noc_local_injector
  import noc_local_injector_pkg::*;
#(
  parameter int VC_NUM = 2,
  parameter int DATA_W = 32,
  parameter int LEN_W  = NOC_LEN_W,
  localparam int VC_W   = $clog2(VC_NUM),
  localparam int FLIT_W = FLIT_TYPE_W + VC_W + DATA_W
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [Noc_ID_X_Width-1:0] src_x,
  input  logic [Noc_ID_Y_Width-1:0] src_y,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [Noc_ID_X_Width-1:0] desc_dst_x,
  input  logic [Noc_ID_Y_Width-1:0] desc_dst_y,
  input  logic [LEN_W-1:0]          desc_len,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [DATA_W-1:0]         data,
  Noc_flit_interface.sender         noc_sender_if
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [31:0]               stat_pkt_cnt,
  output logic [31:0]               stat_flit_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_BODY} state_e;

  state_e            state_q, state_d;
  logic [VC_W-1:0]   vc_q, vc_d, vc_pick, flit_vc;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              run_q;
  logic              can_load, load;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit, flit_d;
  logic [DATA_W-1:0] payload;
  flit_type_e        ftype;
  logic [VC_NUM-1:0] vc_ready;

  assign vc_ready = noc_sender_if.vc_ready;

  // Lowest-index ready VC; the loop runs downward so the lowest hit wins.
  always_comb begin
    vc_pick = '0;
    for (int i = VC_NUM - 1; i >= 0; i--)
      if (vc_ready[i]) vc_pick = VC_W'(i);
  end

  // Packet FSM: descriptor accept in IDLE, one payload word per flit in BODY.
  always_comb begin
    state_d    = state_q;
    vc_d       = vc_q;
    rem_d      = rem_q;
    desc_ready = 1'b0;
    data_ready = 1'b0;
    load       = 1'b0;
    ftype      = FLIT_BODY;
    flit_vc    = vc_q;
    payload    = '0;
    case (state_q)
      ST_IDLE: begin
        // run_q keeps desc_ready low through reset and its first cycle out.
        desc_ready = run_q && can_load && (|vc_ready);
        flit_vc    = vc_pick;
        payload    = DATA_W'({desc_dst_x, desc_dst_y, src_x, src_y, desc_len});
        ftype      = (desc_len == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
        if (desc_valid && desc_ready) begin
          load  = 1'b1;
          vc_d  = vc_pick;
          rem_d = desc_len;
          if (desc_len != '0) state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        // Only the VC owned by this packet gates progress.
        data_ready = can_load && vc_ready[vc_q];
        payload    = data;
        ftype      = (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
        if (data_valid && data_ready) begin
          load  = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flit_d = {ftype, flit_vc, payload};

  // FSM state, owned VC and remaining body count.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q <= ST_IDLE;
      vc_q    <= '0;
      rem_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      rem_q   <= rem_d;
      run_q   <= 1'b1;
    end
  end

  noc_flit_out_reg #(.W(FLIT_W)) u_out (
    .clk      (noc_clk),
    .rst_n    (noc_rst_n),
    .load     (load),
    .din      (flit_d),
    .ready    (noc_sender_if.ready),
    .valid    (out_valid),
    .dout     (out_flit),
    .can_load (can_load)
  );

  assign noc_sender_if.valid   = out_valid;
  assign noc_sender_if.flit[0] = out_flit;

`ifdef NOC_INJ_STATS_EN
  logic       out_hs;
  flit_type_e out_type;

  assign out_hs   = out_valid && noc_sender_if.ready;
  assign out_type = flit_type_e'(out_flit[FLIT_W-1 -: FLIT_TYPE_W]);

  // Free-running counters of delivered flits and completed packets.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      stat_pkt_cnt  <= '0;
      stat_flit_cnt <= '0;
    end else if (out_hs) begin
      stat_flit_cnt <= stat_flit_cnt + 32'd1;
      if (is_last(out_type)) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// Randomized bench for noc_local_injector with a packet-level reference:
// each accepted descriptor expands into its full expected flit list.
module tb_noc_local_injector;
  import noc_local_injector_pkg::*;

  localparam int VC_NUM = 2;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int FLIT_W = 2 + 1 + DATA_W;

  logic                      noc_clk = 1'b0;
  logic                      noc_rst_n = 1'b0;
  logic [Noc_ID_X_Width-1:0] src_x = '0;
  logic [Noc_ID_Y_Width-1:0] src_y = '0;
  logic                      desc_valid = 1'b0;
  logic                      desc_ready;
  logic [Noc_ID_X_Width-1:0] desc_dst_x = '0;
  logic [Noc_ID_Y_Width-1:0] desc_dst_y = '0;
  logic [LEN_W-1:0]          desc_len = '0;
  logic                      data_valid = 1'b0;
  logic                      data_ready;
  logic [DATA_W-1:0]         data = '0;
`ifdef NOC_INJ_STATS_EN
  logic [31:0]               stat_pkt_cnt, stat_flit_cnt;
`endif

  Noc_flit_interface #(.VC_NUM(VC_NUM), .FLIT_W(FLIT_W)) nif ();

  always #5 noc_clk = ~noc_clk;

  noc_local_injector #(.VC_NUM(VC_NUM), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .noc_clk       (noc_clk),
    .noc_rst_n     (noc_rst_n),
    .src_x         (src_x),
    .src_y         (src_y),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_dst_x    (desc_dst_x),
    .desc_dst_y    (desc_dst_y),
    .desc_len      (desc_len),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data          (data),
    .noc_sender_if (nif)
`ifdef NOC_INJ_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_flit_cnt (stat_flit_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  dx, dy, len;
    bit          inc;
    logic [31:0] w0;
  } pkt_t;

  pkt_t              pkt_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [FLIT_W-1:0] exp_q[$];

  int checks = 0, errors = 0, acc_cnt = 0, out_cnt = 0, cur_vc = 0;
  bit rnd = 0, desc_acc = 0, hold_v = 0, loaded_prev = 0;
  logic              rdy_force = 1'b1;
  logic [1:0]        vc_force = 2'b11;
  logic [FLIT_W-1:0] hold_flit = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] t, input int vc,
                                               input logic [31:0] p);
    logic [0:0] v;
    v = vc[0];
    return {t, v, p};
  endfunction

  task automatic drive();
    pkt_t p;
    if (desc_acc) begin desc_valid = 1'b0; desc_acc = 0; end
    if (!desc_valid && pkt_q.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
      p = pkt_q[0];
      desc_valid = 1'b1;
      desc_dst_x = p.dx;
      desc_dst_y = p.dy;
      desc_len   = p.len;
    end
    if (data_q.size() > 0) begin
      data_valid = !rnd || ($urandom_range(0, 3) != 0);
      data       = data_q[0];
    end else begin
      data_valid = rnd && ($urandom_range(0, 7) == 0);
      data       = $urandom;
    end
    nif.ready    = rnd ? ($urandom_range(0, 3) != 0) : rdy_force;
    nif.vc_ready = rnd ? 2'($urandom_range(0, 3)) : vc_force;
  endtask

  // One cycle: sample/check at negedge, then drive just after posedge.
  task automatic step();
    bit loaded;
    pkt_t p;
    logic [31:0] w;
    loaded = 0;
    @(negedge noc_clk);
    if (hold_v) begin
      chk("hold_valid", nif.valid, 1);
      chk("hold_flit", nif.flit[0], hold_flit);
    end
    if (loaded_prev) chk("load_latency", nif.valid, 1);
    if (data_q.size() == 0) chk("data_rdy_idle", data_ready, 0);
    else if (!nif.vc_ready[cur_vc]) chk("data_rdy_vc_stall", data_ready, 0);
    if (data_q.size() != 0 || nif.vc_ready == 2'b00) chk("desc_rdy_block", desc_ready, 0);
    if (nif.valid && nif.ready) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("spurious_flit", 1, 0);
      else chk("flit", nif.flit[0], exp_q.pop_front());
    end
    hold_v    = nif.valid && !nif.ready;
    hold_flit = nif.flit[0];
    if (data_valid && data_ready && data_q.size() > 0) begin
      w = data_q.pop_front();
      exp_q.push_back(mk_flit((data_q.size() == 0) ? 2'b10 : 2'b00, cur_vc, w));
      loaded = 1;
    end
    if (desc_valid && desc_ready && pkt_q.size() > 0) begin
      p = pkt_q.pop_front();
      cur_vc = nif.vc_ready[0] ? 0 : 1;
      exp_q.push_back(mk_flit((p.len == 0) ? 2'b11 : 2'b01, cur_vc,
                              {12'd0, p.dx, p.dy, src_x, src_y, p.len}));
      for (int i = 0; i < int'(p.len); i++)
        data_q.push_back(p.inc ? p.w0 + 32'(i) : 32'($urandom));
      desc_acc = 1;
      acc_cnt++;
      loaded = 1;
    end
    loaded_prev = loaded;
    @(posedge noc_clk);
    #1;
    drive();
  endtask

  task automatic push_pkt(input int dx, input int dy, input int len, input bit inc,
                          input logic [31:0] w0);
    pkt_t p;
    p.dx = 4'(dx); p.dy = 4'(dy); p.len = 4'(len); p.inc = inc; p.w0 = w0;
    pkt_q.push_back(p);
  endtask

  task automatic wait_acc();
    int n0, k;
    n0 = acc_cnt;
    k = 0;
    while (acc_cnt == n0 && k < 50) begin step(); k++; end
    if (acc_cnt == n0) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || data_q.size() != 0 || pkt_q.size() != 0 || desc_valid)
           && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk("drain_timeout", 0, 1);
  endtask

  task automatic set_force(input logic r, input logic [1:0] v);
    rdy_force = r; vc_force = v;
    nif.ready = r; nif.vc_ready = v;
  endtask

  initial begin
    int o0;
    nif.ready = 1'b1;
    nif.vc_ready = 2'b11;
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_valid", nif.valid, 0);
    chk("rst_flit", nif.flit[0], 0);
    chk("rst_desc_rdy", desc_ready, 0);
    chk("rst_data_rdy", data_ready, 0);
`ifdef NOC_INJ_STATS_EN
    chk("rst_stat_pkt", stat_pkt_cnt, 0);
    chk("rst_stat_flit", stat_flit_cnt, 0);
`endif
    noc_rst_n = 1'b1;

    // single HEADTAIL flit, known encoding
    push_pkt(2, 1, 0, 0, 0);
    wait_acc();
    chk("headtail_flit", nif.flit[0], 35'h600021000);
    drain(50);

    // len 3, one flit per cycle
    push_pkt(3, 4, 3, 1, 32'hA);
    wait_acc();
    o0 = out_cnt;
    repeat (4) step();
    chk("len3_consecutive", out_cnt - o0, 4);
    drain(50);

    // back-to-back packets, no bubble
    push_pkt(1, 1, 2, 0, 0);
    push_pkt(5, 6, 0, 0, 0);
    wait_acc();
    o0 = out_cnt;
    repeat (4) step();
    chk("b2b_no_bubble", out_cnt - o0, 4);
    drain(50);

    // VC 1 only, then its ready drops mid-packet (VC 0 becomes ready)
    set_force(1'b1, 2'b10);
    push_pkt(7, 2, 3, 0, 0);
    wait_acc();
    step();
    set_force(1'b1, 2'b01);
    repeat (3) step();
    chk("vc_stall_words_left", data_q.size(), 2);
    chk("vc_stall_data_rdy", data_ready, 0);
    set_force(1'b1, 2'b10);
    drain(50);

    // receiver backpressure for 5 cycles
    set_force(1'b1, 2'b11);
    push_pkt(3, 3, 2, 0, 0);
    wait_acc();
    set_force(1'b0, 2'b11);
    repeat (5) step();
    chk("bp_data_rdy", data_ready, 0);
    chk("bp_valid", nif.valid, 1);
    set_force(1'b1, 2'b11);
    drain(50);

    // reset in the middle of a len-5 packet
    push_pkt(9, 9, 5, 0, 0);
    wait_acc();
    repeat (2) step();
    noc_rst_n = 1'b0;
    #1;
    chk("midrst_valid", nif.valid, 0);
    chk("midrst_desc_rdy", desc_ready, 0);
    exp_q.delete(); data_q.delete(); pkt_q.delete();
    desc_valid = 1'b0; data_valid = 1'b0;
    desc_acc = 0; hold_v = 0; loaded_prev = 0;
    @(posedge noc_clk);
    #1;
    noc_rst_n = 1'b1;

    // first packet after reset starts with a head flit
    push_pkt(4, 5, 2, 0, 0);
    wait_acc();
    chk("post_rst_head", nif.flit[0][FLIT_W-1 -: 2], 2'b01);
    drain(50);
    push_pkt(1, 2, 0, 0, 0);
    drain(50);
    push_pkt(2, 3, 0, 0, 0);
    drain(50);
`ifdef NOC_INJ_STATS_EN
    chk("stat_pkt_cnt", stat_pkt_cnt, 3);
    chk("stat_flit_cnt", stat_flit_cnt, 5);
`endif

    // randomized traffic with random backpressure and VC availability
    rnd = 1;
    src_x = 4'd5;
    src_y = 4'd3;
    for (int i = 0; i < 40; i++)
      push_pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 0, 0);
    drain(5000);
    rnd = 0;
    set_force(1'b1, 2'b11);
    repeat (3) step();
    chk("final_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
